// File: rtl/ifetch_prefetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues credit-limited word requests and buffers responses for decode.
// Define IFETCH_MISALIGN_CHK_EN to add the sticky misaligned-redirect flag (misalign_o / misalign_pc_o).
module ifetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    output logic        misalign_o,
    output logic [31:0] misalign_pc_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_SUM = (CW+1)'(DEPTH);

    localparam logic [0:0] ST_FETCH   = 1'b0;
    localparam logic [0:0] ST_DISCARD = 1'b1;

    logic [0:0]    state_reg, state_next;
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] discard_reg, discard_next;
    logic [CW-1:0] fifo_count_reg, fifo_count_next;
    logic [PW-1:0] fifo_wr_ptr_reg, fifo_wr_ptr_next;
    logic [PW-1:0] fifo_rd_ptr_reg, fifo_rd_ptr_next;
    logic [PW-1:0] tag_wr_ptr_reg, tag_rd_ptr_reg;

    logic [31:0] fifo_inst_mem [DEPTH];
    logic [31:0] fifo_pc_mem   [DEPTH];
    logic [31:0] tag_mem       [DEPTH];

    logic credit_ok;
    logic req_valid;
    logic req_fire;
    logic rsp_fire;
    logic rsp_push;
    logic fifo_nonempty;
    logic id_pop;

    // Buffered plus in-flight words never exceed DEPTH, so the FIFO cannot overflow.
    assign credit_ok     = ({1'b0, fifo_count_reg} + {1'b0, outstanding_reg}) < DEPTH_SUM;
    assign req_valid     = reset & (state_reg == ST_FETCH) & ~redirect_i & credit_ok;
    assign req_fire      = req_valid & imem_req_ready_i;
    // Late responses for requests abandoned by reset find outstanding==0 and are ignored.
    assign rsp_fire      = imem_rsp_valid_i & (outstanding_reg != '0);
    assign rsp_push      = rsp_fire & ~redirect_i & (state_reg == ST_FETCH);
    assign fifo_nonempty = (fifo_count_reg != '0);
    assign id_pop        = fifo_nonempty & id_ready_i & ~redirect_i;

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = fetch_pc_reg;
    assign id_valid_o       = fifo_nonempty;
    assign id_inst_o        = fifo_nonempty ? fifo_inst_mem[fifo_rd_ptr_reg] : '0;
    assign id_pc_o          = fifo_nonempty ? fifo_pc_mem[fifo_rd_ptr_reg]   : '0;

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_fire);
        discard_next     = discard_reg;
        state_next       = state_reg;
        fifo_count_next  = fifo_count_reg + CW'(rsp_push) - CW'(id_pop);
        fifo_wr_ptr_next = fifo_wr_ptr_reg + PW'(rsp_push);
        fifo_rd_ptr_next = fifo_rd_ptr_reg + PW'(id_pop);

        if (redirect_i) begin
            fetch_pc_next    = {redirect_pc_i[31:2], 2'b00};
            // Everything still in flight is stale, except a response landing this very cycle.
            discard_next     = outstanding_reg - CW'(rsp_fire);
            state_next       = (discard_next != '0) ? ST_DISCARD : ST_FETCH;
            fifo_count_next  = '0;
            fifo_wr_ptr_next = '0;
            fifo_rd_ptr_next = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            if ((state_reg == ST_DISCARD) && rsp_fire) begin
                discard_next = discard_reg - CW'(1);
                if (discard_next == '0) begin
                    state_next = ST_FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_FETCH;
            fetch_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            fifo_count_reg  <= '0;
            fifo_wr_ptr_reg <= '0;
            fifo_rd_ptr_reg <= '0;
            tag_wr_ptr_reg  <= '0;
            tag_rd_ptr_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            fifo_count_reg  <= fifo_count_next;
            fifo_wr_ptr_reg <= fifo_wr_ptr_next;
            fifo_rd_ptr_reg <= fifo_rd_ptr_next;
            tag_wr_ptr_reg  <= tag_wr_ptr_reg + PW'(req_fire);
            tag_rd_ptr_reg  <= tag_rd_ptr_reg + PW'(rsp_fire);
        end
    end

    // Storage is data-only; validity lives entirely in the reset counters and pointers.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (req_fire && (tag_wr_ptr_reg == PW'(gi))) begin
                    tag_mem[gi] <= fetch_pc_reg;
                end
                if (rsp_push && (fifo_wr_ptr_reg == PW'(gi))) begin
                    fifo_inst_mem[gi] <= imem_rsp_data_i;
                    fifo_pc_mem[gi]   <= tag_mem[tag_rd_ptr_reg];
                end
            end
        end
    endgenerate

`ifdef IFETCH_MISALIGN_CHK_EN
    logic        misalign_reg;
    logic [31:0] misalign_pc_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_reg    <= 1'b0;
            misalign_pc_reg <= '0;
        end else if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
            misalign_reg    <= 1'b1;
            misalign_pc_reg <= redirect_pc_i;
        end
    end

    assign misalign_o    = misalign_reg;
    assign misalign_pc_o = misalign_pc_reg;
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc_i[1:0];
`endif

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// Scoreboard bench for ifetch_prefetch_unit: a behavioural instruction memory plus queues of expected decode PCs.
module tb_ifetch_prefetch_unit;

    logic        clk;
    logic        reset;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        misalign_o;
    logic [31:0] misalign_pc_o;
`endif

    ifetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_inst_o        (id_inst_o),
        .id_pc_o          (id_pc_o)
`ifdef IFETCH_MISALIGN_CHK_EN
        ,
        .misalign_o       (misalign_o),
        .misalign_pc_o    (misalign_pc_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          n_fire = 0;
    logic        rsp_en;
    logic        last_req_fire;
    logic [31:0] exp_req_addr;
    logic [31:0] mem_q [$];
    logic [31:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // One clock: called at the falling edge with this cycle's inputs set by the caller.
    task automatic cycle();
        logic        req_fire;
        logic        id_fire;
        logic [31:0] req_addr;
        logic [31:0] got_pc;
        logic [31:0] got_inst;
        logic [31:0] e;
        if (rsp_en && mem_q.size() > 0) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = inst_of(mem_q[0]);
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
        end
        id_ready_i = (exp_q.size() > 0);
        #1;
        req_fire = imem_req_valid_o && imem_req_ready_i;
        id_fire  = id_valid_o && id_ready_i;
        req_addr = imem_req_addr_o;
        got_pc   = id_pc_o;
        got_inst = id_inst_o;
        last_req_fire = req_fire;
        if (req_fire) begin
            check_val("req_addr", req_addr, exp_req_addr);
            exp_req_addr = req_addr + 32'd4;
            n_fire++;
        end
        if (id_fire) begin
            e = exp_q.pop_front();
            $display("ID  pc=%h inst=%h expected_pc=%h", got_pc, got_inst, e);
            check_val("id_pc", got_pc, e);
            check_val("id_inst", got_inst, inst_of(e));
        end
        if (redirect_i) exp_req_addr = redirect_pc_i & ~32'd3;
        @(posedge clk);
        if (imem_rsp_valid_i) void'(mem_q.pop_front());
        if (req_fire) mem_q.push_back(req_addr);
        @(negedge clk);
        redirect_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) cycle();
        check_val("drain_left", exp_q.size(), 0);
    endtask

    task automatic push_exp(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        cycle();
    endtask

    // Redirect to base, let base issue, then hold responses until n requests are in flight.
    task automatic setup_outstanding(input logic [31:0] base, input int n);
        imem_req_ready_i = 1'b1;
        rsp_en = 1'b1;
        do_redirect(base);
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (last_req_fire) break;
        end
        rsp_en = 1'b0;
        for (int i = 0; i < 20 && mem_q.size() < n; i++) cycle();
        check_val("setup_inflight", mem_q.size(), n);
    endtask

    initial begin
        reset            = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        id_ready_i       = 1'b0;
        rsp_en           = 1'b1;
        exp_req_addr     = 32'h0;
        last_req_fire    = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check_val("rst_req_valid", imem_req_valid_o, 0);
        check_val("rst_id_valid", id_valid_o, 0);
        check_val("rst_addr", imem_req_addr_o, 32'h0);
`ifdef IFETCH_MISALIGN_CHK_EN
        check_val("rst_misalign", misalign_o, 0);
`endif
        reset = 1'b1;

        // Back-pressure: decode stalled, credits run out after DEPTH requests.
        n_fire = 0;
        for (int i = 0; i < 8; i++) cycle();
        check_val("bp_fires", n_fire, 4);
        check_val("bp_req_valid", imem_req_valid_o, 0);
        check_val("bp_head_pc", id_pc_o, 32'h0);

        // Release and stream: after warm-up one request per cycle.
        push_exp(32'h0, 26);
        for (int i = 0; i < 4; i++) cycle();
        n_fire = 0;
        for (int i = 0; i < 10; i++) cycle();
        check_val("stream_rate", n_fire, 10);
        drain();

        // Request stall at 0x20.
        imem_req_ready_i = 1'b0;
        do_redirect(32'h20);
        for (int i = 0; i < 20 && !imem_req_valid_o; i++) cycle();
        for (int i = 0; i < 5; i++) begin
            check_val("stall_valid", imem_req_valid_o, 1);
            check_val("stall_addr", imem_req_addr_o, 32'h20);
            cycle();
        end
        imem_req_ready_i = 1'b1;
        push_exp(32'h20, 2);
        drain();

        // Redirect with 3 outstanding and one buffered word.
        setup_outstanding(32'h40, 4);
        rsp_en = 1'b1;
        cycle();
        rsp_en = 1'b0;
        check_val("pre_flush_valid", id_valid_o, 1);
        check_val("pre_flush_pc", id_pc_o, 32'h40);
        do_redirect(32'h100);
        check_val("flush_id_valid", id_valid_o, 0);
        check_val("disc_req_blocked", imem_req_valid_o, 0);
        rsp_en = 1'b1;
        push_exp(32'h100, 2);
        drain();

        // Redirect coinciding with a response, then a second redirect while discarding.
        setup_outstanding(32'h80, 2);
        rsp_en = 1'b1;
        do_redirect(32'h180);
        rsp_en = 1'b0;
        cycle();
        check_val("disc1_req_blocked", imem_req_valid_o, 0);
        check_val("disc1_id_valid", id_valid_o, 0);
        do_redirect(32'h200);
        rsp_en = 1'b1;
        push_exp(32'h200, 2);
        drain();

        // Misaligned redirect: fetch continues from the aligned address.
        do_redirect(32'h103);
`ifdef IFETCH_MISALIGN_CHK_EN
        check_val("mis_flag", misalign_o, 1);
        check_val("mis_pc", misalign_pc_o, 32'h103);
`endif
        push_exp(32'h100, 2);
        drain();
        do_redirect(32'h40);
`ifdef IFETCH_MISALIGN_CHK_EN
        check_val("mis_sticky", misalign_o, 1);
        check_val("mis_pc_sticky", misalign_pc_o, 32'h103);
`endif

        // Asynchronous reset in the middle of outstanding traffic.
        setup_outstanding(32'h400, 3);
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_req_valid", imem_req_valid_o, 0);
        check_val("arst_id_valid", id_valid_o, 0);
        check_val("arst_addr", imem_req_addr_o, 32'h0);
`ifdef IFETCH_MISALIGN_CHK_EN
        check_val("arst_misalign", misalign_o, 0);
`endif
        mem_q.delete();
        imem_rsp_valid_i = 1'b0;
        exp_req_addr = 32'h0;
        @(negedge clk);
        reset  = 1'b1;
        rsp_en = 1'b1;
        push_exp(32'h0, 3);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
